regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Writeback scheduler for the SEQ register file. Buffers per-instruction writeback bundles
//  {dstE,valE,dstM,valM} and serialises them onto the single register-file write port.
//  Gives decode a pending-write scoreboard so it can stall on RAW hazards.
//  Sits between the execute/memory stages and the register module.
// PARAMETERS
//  DEPTH  2   bundle FIFO entries (power of 2, >=2)
//  W      64  data width of valE/valM
//  NREG   15  architectural registers (ids 0..14); id 4'hF = RNONE (no write)
// PORTS
//  clk                     in   1    clock, rising edge
//  reset                   in   1    asynchronous, active-low reset
//  wb_valid                in   1    writeback bundle offered
//  wb_ready                out  1    bundle accepted when wb_valid & wb_ready at clk edge
//  wb_dstE                 in   4    E destination (F = none)
//  wb_valE                 in   W    E value
//  wb_dstM                 in   4    M destination (F = none)
//  wb_valM                 in   W    M value
//  rf_wrEn                 out  1    register-file write strobe
//  rf_registernumber_write out  4    register-file write address
//  rf_val_write            out  W    register-file write data
//  chk_reg1, chk_reg2      in   4    decode source ids to check (F = none)
//  stall                   out  1    a checked id has a pending write
//  busy                    out  NREG pending-write bitmap
//  idle                    out  1    FIFO empty and FSM in S_IDLE
// BEHAVIOUR
//  - Reset (async, low): FIFO flushed; state=S_IDLE; rf_wrEn=0; rf_registernumber_write=F;
//    rf_val_write=0; busy=0; stall=0; idle=1; wb_ready=1 after release.
//  - wb_ready = !full. Ready never depends on a same-cycle pop.
//  - FSM:
//    * S_IDLE -> S_E when the FIFO is non-empty.
//    * S_E: if head.dstE!=F, register a write {dstE,valE}; go to S_M.
//    * S_M: if head.dstM!=F, register a write {dstM,valM}; pop the head.
//      Go to S_E if a further entry exists, else to S_IDLE.
//  - Write outputs are registered. For a bundle accepted at edge t into an empty, idle block,
//    the E write is visible in cycle t+2 and the M write in cycle t+3.
//    Each bundle occupies exactly 2 FSM cycles, even when a dst is F.
//  - Ordering: E is always written before M, and bundles are written in FIFO order.
//    When dstE==dstM, valM is the final value (popq %rsp semantics).
//  - busy[r]=1 while any accepted, not-yet-written write targets r. The flag clears on the
//    edge its write is registered. A bundle being accepted in the current cycle is not included.
//  - stall = (chk_reg1!=F & busy[chk_reg1]) | (chk_reg2!=F & busy[chk_reg2]).
//  - Both dst=F: the bundle is consumed with no rf_wrEn pulses.
//  - Reset mid-bundle: pending writes are discarded. No partial write occurs after reset asserts.
// CONFIGURATION
//  WB_FORWARD_EN defined: adds outputs
//    fwd_hit1, fwd_hit2  out  1  checked id has a pending write
//    fwd_val1, fwd_val2  out  W  value of the youngest pending write to that id
//  A hit reg is excluded from stall, so stall is asserted only for non-forwardable cases (none).
//  WB_FORWARD_EN undefined: forwarding ports absent; stall exactly as in BEHAVIOUR.
// STRUCTURE
//  Package regfile_wb_pkg contains:
//    RNONE=4'hF; state enum {S_IDLE,S_E,S_M}; wb_bundle_t struct {dstE,valE,dstM,valM}.
//  Sub-module wb_fifo:
//    DEPTH-entry bundle FIFO, per-entry e_done flag, exposes all entries for busy/forward scan.
//  The top level holds the FSM, the write-port registers and the scoreboard logic.
// TESTING
//  1. Push {3,80,F,-} -> single write r3=80; busy[3] clears; idle=1 two cycles later.
//  2. Push {4,20,4,99} -> writes r4=20 then r4=99 on consecutive cycles; final r4=99.
//  3. Three back-to-back valid bundles, DEPTH=2 -> wb_ready=0 after two accepts;
//     third accepted the cycle after the first pop.
//  4. Pending {7,5,F,-} with chk_reg1=7 -> stall=1 until the write registers;
//     chk_reg1=F -> stall=0.
//  5. Reset low during S_M of {2,1,3,2} -> rf_wrEn=0 immediately; no r3 write;
//     busy=0, idle=1 after release.
//  6. WB_FORWARD_EN: pending {2,0x55,F,-}, chk_reg2=2 -> fwd_hit2=1, fwd_val2=0x55, stall=0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types for the SEQ register-file writeback scheduler.
// Bundle value width is fixed here; the top-level W must match WB_W.
package regfile_wb_pkg;

    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         WB_W     = 64;
    localparam int         WB_NREG  = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_E,
        S_M
    } state_t;

    typedef struct packed {
        logic [3:0]      dstE;
        logic [WB_W-1:0] valE;
        logic [3:0]      dstM;
        logic [WB_W-1:0] valM;
    } wb_bundle_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback bundle FIFO with a per-entry "E already written" flag.
// All entries are exposed oldest-first for pending-write and forward scans.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  wb_bundle_t       i_data,
    input  logic             i_pop,
    input  logic             i_e_done,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_more,
    output wb_bundle_t       o_ent [DEPTH],
    output logic [DEPTH-1:0] o_vld,
    output logic [DEPTH-1:0] o_edone
);

    localparam int AW = $clog2(DEPTH);

    wb_bundle_t       r_mem [DEPTH];
    logic [DEPTH-1:0] r_edone;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;
    logic [AW-1:0]    w_idx [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_edone <= '0;
        end else begin
            if (i_push) begin
                r_wr          <= r_wr + AW'(1);
                r_edone[r_wr] <= 1'b0;
            end
            if (i_e_done)
                r_edone[r_rd] <= 1'b1;
            if (i_pop)
                r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    // Payload storage needs no reset: validity is carried by r_cnt.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_more  = (r_cnt > (AW+1)'(1));

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_idx[k]   = r_rd + AW'(k);
            o_ent[k]   = r_mem[w_idx[k]];
            o_edone[k] = r_edone[w_idx[k]];
            o_vld[k]   = ((AW+1)'(k) < r_cnt);
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Serialises {dstE,valE,dstM,valM} bundles onto one register-file write port.
// Optional WB_FORWARD_EN adds forwarding of pending values to decode.
module regfile_wb_scheduler
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = WB_W,
    parameter int NREG  = WB_NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [3:0]      wb_dstE,
    input  logic [W-1:0]    wb_valE,
    input  logic [3:0]      wb_dstM,
    input  logic [W-1:0]    wb_valM,
    output logic            rf_wrEn,
    output logic [3:0]      rf_registernumber_write,
    output logic [W-1:0]    rf_val_write,
    input  logic [3:0]      chk_reg1,
    input  logic [3:0]      chk_reg2,
    output logic            stall,
    output logic [NREG-1:0] busy,
`ifdef WB_FORWARD_EN
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [W-1:0]    fwd_val1,
    output logic [W-1:0]    fwd_val2,
`endif
    output logic            idle
);

    wb_bundle_t       w_in;
    wb_bundle_t       w_ent [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [DEPTH-1:0] w_edone;
    logic             w_full;
    logic             w_empty;
    logic             w_more;
    logic             w_push;

    state_t           r_state;
    state_t           w_next;
    logic             r_wr;
    logic [3:0]       r_addr;
    logic [W-1:0]     r_val;
    logic             w_wr;
    logic [3:0]       w_addr;
    logic [W-1:0]     w_val;
    logic             w_pop;
    logic             w_set_e;
    logic [15:0]      w_pend;
    logic             w_p1;
    logic             w_p2;

    assign w_in     = '{dstE: wb_dstE, valE: wb_valE,
                        dstM: wb_dstM, valM: wb_valM};
    assign wb_ready = ~w_full;
    assign w_push   = wb_valid & ~w_full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push),
        .i_data   (w_in),
        .i_pop    (w_pop),
        .i_e_done (w_set_e),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_more   (w_more),
        .o_ent    (w_ent),
        .o_vld    (w_vld),
        .o_edone  (w_edone)
    );

    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_addr  = RNONE;
        w_val   = '0;
        w_pop   = 1'b0;
        w_set_e = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty)
                    w_next = S_E;
            end
            S_E: begin
                w_set_e = 1'b1;
                w_next  = S_M;
                if (w_ent[0].dstE != RNONE) begin
                    w_wr   = 1'b1;
                    w_addr = w_ent[0].dstE;
                    w_val  = w_ent[0].valE;
                end
            end
            S_M: begin
                w_pop  = 1'b1;
                w_next = w_more ? S_E : S_IDLE;
                if (w_ent[0].dstM != RNONE) begin
                    w_wr   = 1'b1;
                    w_addr = w_ent[0].dstM;
                    w_val  = w_ent[0].valM;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_addr  <= RNONE;
            r_val   <= '0;
        end else begin
            r_state <= w_next;
            r_wr    <= w_wr;
            r_addr  <= w_addr;
            r_val   <= w_val;
        end
    end

    assign rf_wrEn                 = r_wr;
    assign rf_registernumber_write = r_addr;
    assign rf_val_write            = r_val;

    // An E write stops being pending once e_done is set; M stays until pop.
    always_comb begin
        w_pend = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_vld[k]) begin
                if (!w_edone[k] && w_ent[k].dstE != RNONE)
                    w_pend[w_ent[k].dstE] = 1'b1;
                if (w_ent[k].dstM != RNONE)
                    w_pend[w_ent[k].dstM] = 1'b1;
            end
        end
    end

    assign busy = w_pend[NREG-1:0];
    assign w_p1 = (chk_reg1 != RNONE) & w_pend[chk_reg1];
    assign w_p2 = (chk_reg2 != RNONE) & w_pend[chk_reg2];
    assign idle = w_empty & (r_state == S_IDLE);

`ifdef WB_FORWARD_EN
    // Oldest-to-youngest scan so the last match is the youngest value.
    always_comb begin
        fwd_val1 = '0;
        fwd_val2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_vld[k]) begin
                if (!w_edone[k] && w_ent[k].dstE == chk_reg1)
                    fwd_val1 = w_ent[k].valE;
                if (w_ent[k].dstM == chk_reg1)
                    fwd_val1 = w_ent[k].valM;
                if (!w_edone[k] && w_ent[k].dstE == chk_reg2)
                    fwd_val2 = w_ent[k].valE;
                if (w_ent[k].dstM == chk_reg2)
                    fwd_val2 = w_ent[k].valM;
            end
        end
    end

    assign fwd_hit1 = w_p1;
    assign fwd_hit2 = w_p2;
    assign stall    = (w_p1 & ~fwd_hit1) | (w_p2 & ~fwd_hit2);
`else
    assign stall    = w_p1 | w_p2;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomised bench for regfile_wb_scheduler against a timeline model.
// Each accepted bundle is assigned its E/M write cycles at acceptance.
module tb_regfile_wb_scheduler;

    localparam int DEPTH = 2;
    localparam int W     = 64;
    localparam int NREG  = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid;
    logic            wb_ready;
    logic [3:0]      wb_dstE;
    logic [W-1:0]    wb_valE;
    logic [3:0]      wb_dstM;
    logic [W-1:0]    wb_valM;
    logic            rf_wrEn;
    logic [3:0]      rf_registernumber_write;
    logic [W-1:0]    rf_val_write;
    logic [3:0]      chk_reg1;
    logic [3:0]      chk_reg2;
    logic            stall;
    logic [NREG-1:0] busy;
    logic            idle;
`ifdef WB_FORWARD_EN
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [W-1:0]    fwd_val1;
    logic [W-1:0]    fwd_val2;
`endif

    regfile_wb_scheduler #(.DEPTH(DEPTH), .W(W), .NREG(NREG)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .wb_valid                (wb_valid),
        .wb_ready                (wb_ready),
        .wb_dstE                 (wb_dstE),
        .wb_valE                 (wb_valE),
        .wb_dstM                 (wb_dstM),
        .wb_valM                 (wb_valM),
        .rf_wrEn                 (rf_wrEn),
        .rf_registernumber_write (rf_registernumber_write),
        .rf_val_write            (rf_val_write),
        .chk_reg1                (chk_reg1),
        .chk_reg2                (chk_reg2),
        .stall                   (stall),
        .busy                    (busy),
`ifdef WB_FORWARD_EN
        .fwd_hit1                (fwd_hit1),
        .fwd_hit2                (fwd_hit2),
        .fwd_val1                (fwd_val1),
        .fwd_val2                (fwd_val2),
`endif
        .idle                    (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        int          e;
        int          m;
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
    } mb_t;

    mb_t mq[$];
    int  cyc;
    int  last_m;
    int  checks;
    int  fails;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int count_at(input int n);
        int c = 0;
        foreach (mq[i])
            if (mq[i].a <= n && mq[i].m > n) c++;
        return c;
    endfunction

    // Model: bundle accepted at edge a writes E at max(a+2, prev M+1), M one later.
    initial begin
        mb_t b;
        bit  ok;
        cyc    = 0;
        last_m = -100;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                last_m = -100;
                cyc++;
            end else begin
                ok = (count_at(cyc) < DEPTH);
                cyc++;
                if (wb_valid && ok) begin
                    b.a  = cyc;
                    b.e  = (cyc + 2 > last_m + 1) ? cyc + 2 : last_m + 1;
                    b.m  = b.e + 1;
                    b.de = wb_dstE;
                    b.ve = wb_valE;
                    b.dm = wb_dstM;
                    b.vm = wb_valM;
                    last_m = b.m;
                    mq.push_back(b);
                end
                while (mq.size() > 0 && mq[0].m < cyc - 2)
                    void'(mq.pop_front());
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        logic        ew;
        logic [3:0]  ea;
        logic [63:0] ev;
        logic [15:0] eb;
        int          n;
        int          cnt;
`ifdef WB_FORWARD_EN
        logic [63:0] f1;
        logic [63:0] f2;
`endif
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_wrEn", rf_wrEn, 0);
                chk("rst_addr", rf_registernumber_write, 4'hF);
                chk("rst_val", rf_val_write, 0);
                chk("rst_busy", busy, 0);
                chk("rst_stall", stall, 0);
                chk("rst_idle", idle, 1);
            end else begin
                n  = cyc;
                ew = 0;
                ea = 4'hF;
                ev = 0;
                eb = 0;
                cnt = count_at(n);
`ifdef WB_FORWARD_EN
                f1 = 0;
                f2 = 0;
`endif
                foreach (mq[i]) begin
                    if (mq[i].e == n && mq[i].de != 4'hF) begin
                        ew = 1; ea = mq[i].de; ev = mq[i].ve;
                    end
                    if (mq[i].m == n && mq[i].dm != 4'hF) begin
                        ew = 1; ea = mq[i].dm; ev = mq[i].vm;
                    end
                    if (mq[i].a <= n) begin
                        if (mq[i].de != 4'hF && mq[i].e > n) begin
                            eb[mq[i].de] = 1;
`ifdef WB_FORWARD_EN
                            if (mq[i].de == chk_reg1) f1 = mq[i].ve;
                            if (mq[i].de == chk_reg2) f2 = mq[i].ve;
`endif
                        end
                        if (mq[i].dm != 4'hF && mq[i].m > n) begin
                            eb[mq[i].dm] = 1;
`ifdef WB_FORWARD_EN
                            if (mq[i].dm == chk_reg1) f1 = mq[i].vm;
                            if (mq[i].dm == chk_reg2) f2 = mq[i].vm;
`endif
                        end
                    end
                end
                chk("wrEn", rf_wrEn, ew);
                chk("wr_addr", rf_registernumber_write, ea);
                chk("wr_val", rf_val_write, ev);
                chk("busy", busy, eb[NREG-1:0]);
                chk("ready", wb_ready, cnt < DEPTH);
                chk("idle", idle, cnt == 0);
`ifdef WB_FORWARD_EN
                chk("stall", stall, 0);
                chk("fwd_hit1", fwd_hit1, eb[chk_reg1]);
                chk("fwd_hit2", fwd_hit2, eb[chk_reg2]);
                if (eb[chk_reg1]) chk("fwd_val1", fwd_val1, f1);
                if (eb[chk_reg2]) chk("fwd_val2", fwd_val2, f2);
`else
                chk("stall", stall, eb[chk_reg1] | eb[chk_reg2]);
`endif
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        logic r;
        int   t = 0;
        wb_valid = 1;
        wb_dstE  = de;
        wb_valE  = ve;
        wb_dstM  = dm;
        wb_valM  = vm;
        do begin
            r = wb_ready;
            step(1);
            t++;
        end while (!r && t < 50);
        if (!r) chk("push_timeout", 0, 1);
        wb_valid = 0;
    endtask

    initial begin
        int a0;
        int a2;
        reset    = 0;
        wb_valid = 0;
        wb_dstE  = 4'hF;
        wb_valE  = 0;
        wb_dstM  = 4'hF;
        wb_valM  = 0;
        chk_reg1 = 4'hF;
        chk_reg2 = 4'hF;
        checks   = 0;
        fails    = 0;
        step(3);
        chk("lit_rst_addr", rf_registernumber_write, 4'hF);
        chk("lit_rst_idle", idle, 1);
        reset = 1;
        step(1);
        chk("lit_ready_after_rst", wb_ready, 1);

        push(4'd3, 64'd80, 4'hF, 64'd0);
        chk("t1_busy3", busy[3], 1);
        step(2);
        chk("t1_wr", rf_wrEn, 1);
        chk("t1_addr", rf_registernumber_write, 4'd3);
        chk("t1_val", rf_val_write, 64'd80);
        chk("t1_busy3_clr", busy[3], 0);
        step(1);
        chk("t1_noM", rf_wrEn, 0);
        chk("t1_idle", idle, 1);
        step(2);

        push(4'd4, 64'd20, 4'd4, 64'd99);
        step(2);
        chk("t2_e_addr", rf_registernumber_write, 4'd4);
        chk("t2_e_val", rf_val_write, 64'd20);
        step(1);
        chk("t2_m_wr", rf_wrEn, 1);
        chk("t2_m_val", rf_val_write, 64'd99);
        step(2);

        push(4'd1, 64'd11, 4'd2, 64'd12);
        a0 = cyc;
        push(4'd5, 64'd13, 4'd6, 64'd14);
        chk("t3_full", wb_ready, 0);
        push(4'd8, 64'd15, 4'd9, 64'd16);
        a2 = cyc;
        chk("t3_third_accept", a2 - a0, 4);
        step(6);

        chk_reg1 = 4'd7;
        push(4'd7, 64'd5, 4'hF, 64'd0);
`ifndef WB_FORWARD_EN
        chk("t4_stall_a", stall, 1);
        step(1);
        chk("t4_stall_b", stall, 1);
        step(1);
        chk("t4_stall_clr", stall, 0);
`else
        chk("t6_stall", stall, 0);
        step(2);
`endif
        chk_reg1 = 4'hF;
        chk_reg2 = 4'd2;
        push(4'd2, 64'h55, 4'hF, 64'd0);
`ifdef WB_FORWARD_EN
        chk("t6_hit2", fwd_hit2, 1);
        chk("t6_val2", fwd_val2, 64'h55);
`else
        chk("t4_chkF", stall, 1);
`endif
        chk_reg2 = 4'hF;
        step(4);

        push(4'd2, 64'd1, 4'd3, 64'd2);
        step(2);
        chk("t5_e_wr", rf_wrEn, 1);
        reset = 0;
        #1;
        chk("t5_rst_wrEn", rf_wrEn, 0);
        chk("t5_rst_busy", busy, 0);
        step(2);
        reset = 1;
        step(1);
        chk("t5_idle", idle, 1);
        chk("t5_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_r3", rf_wrEn, 0);
            step(1);
        end

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                wb_valid = 0;
                reset = 0;
                step(2);
                reset = 1;
            end
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_dstE  = ($urandom_range(0, 3) == 0) ? 4'hF
                                                   : 4'($urandom_range(0, 14));
            wb_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF
                                                   : 4'($urandom_range(0, 14));
            wb_valE  = {$urandom, $urandom};
            wb_valM  = {$urandom, $urandom};
            chk_reg1 = 4'($urandom_range(0, 15));
            chk_reg2 = 4'($urandom_range(0, 15));
            step(1);
        end
        wb_valid = 0;
        step(10);
        chk("drain_idle", idle, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
